lmdpl_nand_sequencer: RTL and testbench

LMDPL_NAND_SEQUENCER -- requirements
Module: lmdpl_nand_sequencer

---
 rtl/lmdpl_pkg.sv | 21 ++
 rtl/lmdpl_nand_sequencer_if.sv | 33 +++
 rtl/lmdpl_mask_lfsr.sv | 37 +++
 rtl/lmdpl_nand_sequencer.sv | 156 +++++++++++++++
 tb/tb_lmdpl_nand_sequencer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/lmdpl_pkg.sv
// Shared types and constants for the LMDPL NAND sequencer and its mask LFSR.
package lmdpl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_EVAL = 3'd2,
    ST_HOLD = 3'd3,
    ST_CAPT = 3'd4,
    ST_DONE = 3'd5
  } seq_state_e;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lmdpl_nand_sequencer_if.sv
// Operand, result, seed and gate-side signals of the NAND sequencer.
// master = environment (operand source, consumer, gate); slave = sequencer.
interface lmdpl_nand_sequencer_if;
  logic        op_valid;
  logic        op_ready;
  logic        op_a;
  logic        op_b;
  logic        seed_load;
  logic [15:0] seed;
  logic        gate_precharge;
  logic        gate_in0;
  logic        gate_in1;
  logic        gate_m_in0;
  logic        gate_m_in1;
  logic        gate_m_out;
  logic        gate_out;
  logic        res_valid;
  logic        res_ready;
  logic        res_data;
  logic [15:0] op_count;

  modport master (
    output op_valid, op_a, op_b, seed_load, seed, gate_out, res_ready,
    input  op_ready, gate_precharge, gate_in0, gate_in1,
           gate_m_in0, gate_m_in1, gate_m_out, res_valid, res_data, op_count
  );

  modport slave (
    input  op_valid, op_a, op_b, seed_load, seed, gate_out, res_ready,
    output op_ready, gate_precharge, gate_in0, gate_in1,
           gate_m_in0, gate_m_in1, gate_m_out, res_valid, res_data, op_count
  );
endinterface

// File: rtl/lmdpl_mask_lfsr.sv
// Free-running 16-bit Fibonacci LFSR supplying random mask bits.
// A zero seed would lock the register, so it is replaced by SEED.
module lmdpl_mask_lfsr
  import lmdpl_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // Next value: advance every cycle unless a reload is requested.
  always_comb begin
    state_d = lfsr_next(state_q);
    if (load) begin
      state_d = (seed == 16'h0000) ? SEED : seed;
    end
  end

  // State register with synchronous reset to the seed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/lmdpl_nand_sequencer.sv
// Sequences one masked LMDPL NAND evaluation per operand pair.
// All gate-facing outputs are registered from the next state so the gate
// never sees decode glitches.
//
// state | meaning
// IDLE  | precharging, waiting for an operand pair
// PRE   | operands and masks presented, gate still precharged
// EVAL  | precharge released, gate evaluates
// HOLD  | evaluation held for a second cycle
// CAPT  | precharge restored, gate output captured into res_data
// DONE  | result offered until the consumer accepts it
module lmdpl_nand_sequencer
  import lmdpl_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input logic                   clk,
  input logic                   rst_n,
  lmdpl_nand_sequencer_if.slave bus
);

  seq_state_e  state_q, state_d;
  logic        opa_q, opa_d;
  logic        opb_q, opb_d;
  logic [2:0]  mask_q, mask_d;
  logic        res_data_q, res_data_d;
  logic [15:0] op_count_q, op_count_d;

  logic        op_ready_q, op_ready_d;
  logic        res_valid_q, res_valid_d;
  logic        precharge_q, precharge_d;
  logic        in0_q, in0_d;
  logic        in1_q, in1_d;
  logic [2:0]  mask_out_q, mask_out_d;

  logic [15:0] lfsr_state;
  logic        unused_lfsr_bits;

  lmdpl_mask_lfsr #(
    .SEED(SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (bus.seed_load),
    .seed (bus.seed),
    .state(lfsr_state)
  );

  // Only the low three LFSR bits are used as masks.
  assign unused_lfsr_bits = ^lfsr_state[15:3];

  // Next-state, operand latching and registered-output decode.
  always_comb begin
    state_d     = state_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    mask_d      = mask_q;
    res_data_d  = res_data_q;
    op_count_d  = op_count_q;
    op_ready_d  = 1'b0;
    res_valid_d = 1'b0;
    precharge_d = 1'b1;
    in0_d       = 1'b0;
    in1_d       = 1'b0;
    mask_out_d  = 3'b000;

    case (state_q)
      ST_IDLE: begin
        if (bus.op_valid) begin
          opa_d   = bus.op_a;
          opb_d   = bus.op_b;
          // Masks come from the LFSR value before any same-cycle reload.
          mask_d  = lfsr_state[2:0];
          state_d = ST_PRE;
        end
      end
      ST_PRE:  state_d = ST_EVAL;
      ST_EVAL: state_d = ST_HOLD;
      ST_HOLD: state_d = ST_CAPT;
      ST_CAPT: begin
        res_data_d = bus.gate_out;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          state_d = ST_IDLE;
          if (op_count_q != 16'hFFFF) begin
            op_count_d = op_count_q + 16'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_IDLE: op_ready_d = 1'b1;
      ST_PRE: begin
        in0_d      = opa_d;
        in1_d      = opb_d;
        mask_out_d = mask_d;
      end
      ST_EVAL, ST_HOLD: begin
        precharge_d = 1'b0;
        in0_d       = opa_d;
        in1_d       = opb_d;
        mask_out_d  = mask_d;
      end
      ST_CAPT: mask_out_d = mask_d;
      ST_DONE: res_valid_d = 1'b1;
      default: op_ready_d = 1'b0;
    endcase
  end

  // State, latched operation data and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      opa_q       <= 1'b0;
      opb_q       <= 1'b0;
      mask_q      <= 3'b000;
      res_data_q  <= 1'b0;
      op_count_q  <= 16'h0000;
      op_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      precharge_q <= 1'b1;
      in0_q       <= 1'b0;
      in1_q       <= 1'b0;
      mask_out_q  <= 3'b000;
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      mask_q      <= mask_d;
      res_data_q  <= res_data_d;
      op_count_q  <= op_count_d;
      op_ready_q  <= op_ready_d;
      res_valid_q <= res_valid_d;
      precharge_q <= precharge_d;
      in0_q       <= in0_d;
      in1_q       <= in1_d;
      mask_out_q  <= mask_out_d;
    end
  end

  assign bus.op_ready       = op_ready_q;
  assign bus.res_valid      = res_valid_q;
  assign bus.res_data       = res_data_q;
  assign bus.op_count       = op_count_q;
  assign bus.gate_precharge = precharge_q;
  assign bus.gate_in0       = in0_q;
  assign bus.gate_in1       = in1_q;
  assign bus.gate_m_in0     = mask_out_q[2];
  assign bus.gate_m_in1     = mask_out_q[1];
  assign bus.gate_m_out     = mask_out_q[0];

endmodule

// File: tb/tb_lmdpl_nand_sequencer.sv
// Bench for the LMDPL NAND sequencer: random operand pairs checked against a
// transaction-level model (operation phase table, mask LFSR, result counter).
module tb_lmdpl_nand_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lmdpl_nand_sequencer_if bus();

  lmdpl_nand_sequencer #(
    .SEED(16'hACE1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [15:0] ref_lfsr;
  logic [15:0] exp_count = 16'h0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference mask generator: x^16+x^14+x^13+x^11, zero seed falls back to ACE1.
  always @(posedge clk) begin
    if (!rst_n) ref_lfsr <= 16'hACE1;
    else if (bus.seed_load) ref_lfsr <= (bus.seed == 16'h0000) ? 16'hACE1 : bus.seed;
    else ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
  end

  // Downstream gate: evaluates NAND while precharge is low, clears otherwise.
  always @(posedge clk) begin
    bus.gate_out <= bus.gate_precharge ? 1'b0 : ~(bus.gate_in0 & bus.gate_in1);
  end

  function automatic logic [31:0] gate_vec();
    return 32'({bus.gate_in0, bus.gate_in1, bus.gate_m_in0, bus.gate_m_in1, bus.gate_m_out});
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_op_ready"}, 32'(bus.op_ready), 32'(1));
    check({tag, "_precharge"}, 32'(bus.gate_precharge), 32'(1));
    check({tag, "_gate_vec"}, gate_vec(), 32'(0));
    check({tag, "_res_valid"}, 32'(bus.res_valid), 32'(0));
  endtask

  // One full operation. Phase k after the accepting edge: 1=PRE 2=EVAL 3=HOLD 4=CAPT 5=DONE.
  task automatic run_op(input logic a, input logic b, input int ready_delay,
                        input bit seed_in_hold, output logic [2:0] m_obs,
                        output logic [2:0] m_exp);
    int guard = 0;
    logic exp_res;
    while (bus.op_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", 32'(bus.op_ready), 32'(1));
    m_exp = ref_lfsr[2:0];
    m_obs = 3'b000;
    exp_res = ~(a & b);
    bus.op_valid = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      check("precharge", 32'(bus.gate_precharge), 32'((k == 1) || (k == 4)));
      check("gate_ops", 32'({bus.gate_in0, bus.gate_in1}), (k <= 3) ? 32'({a, b}) : 32'(0));
      check("gate_masks", 32'({bus.gate_m_in0, bus.gate_m_in1, bus.gate_m_out}), 32'(m_exp));
      check("busy_ready", 32'(bus.op_ready), 32'(0));
      check("busy_valid", 32'(bus.res_valid), 32'(0));
      if (k == 1) m_obs = {bus.gate_m_in0, bus.gate_m_in1, bus.gate_m_out};
      bus.op_valid  = 1'($urandom);
      bus.op_a      = 1'($urandom);
      bus.op_b      = 1'($urandom);
      bus.res_ready = 1'($urandom);
      bus.seed      = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      bus.seed_load = (seed_in_hold && k == 3) || ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    bus.seed_load = 1'b0;
    for (int d = 0; d <= ready_delay; d++) begin
      check("done_valid", 32'(bus.res_valid), 32'(1));
      check("done_data", 32'(bus.res_data), 32'(exp_res));
      check("done_ready", 32'(bus.op_ready), 32'(0));
      check("done_gate", {31'd0, bus.gate_precharge} | (gate_vec() << 1), 32'(1));
      check("done_count", 32'(bus.op_count), 32'(exp_count));
      bus.res_ready = (d == ready_delay);
      bus.op_valid  = 1'($urandom);
      bus.op_a      = 1'($urandom);
      bus.op_b      = 1'($urandom);
      @(negedge clk);
    end
    bus.op_valid = 1'b0;
    if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
    check_quiet("after_done");
    check("after_count", 32'(bus.op_count), 32'(exp_count));
    check("after_data", 32'(bus.res_data), 32'(exp_res));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] mo, me;
    logic [2:0] obs_first, exp_first;
    bit obs_vary, exp_vary;
    logic ta, tb_b;

    bus.op_valid = 1'b0;
    bus.op_a = 1'b0;
    bus.op_b = 1'b0;
    bus.seed_load = 1'b0;
    bus.seed = 16'h0000;
    bus.res_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_quiet("reset");
    check("reset_data", 32'(bus.res_data), 32'(0));
    check("reset_count", 32'(bus.op_count), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("idle");

    // Basic 1 NAND 1 with immediate consumer.
    bus.res_ready = 1'b1;
    run_op(1'b1, 1'b1, 0, 1'b0, mo, me);
    check("first_count", 32'(bus.op_count), 32'(1));

    // All four operand pairs from a known seed; masks must vary.
    bus.seed_load = 1'b1;
    bus.seed = 16'h0001;
    @(negedge clk);
    bus.seed_load = 1'b0;
    obs_vary = 1'b0;
    exp_vary = 1'b0;
    obs_first = 3'b000;
    exp_first = 3'b000;
    for (int p = 0; p < 4; p++) begin
      run_op(p[1], p[0], 0, 1'b0, mo, me);
      if (p == 0) begin
        obs_first = mo;
        exp_first = me;
      end else begin
        if (mo != obs_first) obs_vary = 1'b1;
        if (me != exp_first) exp_vary = 1'b1;
      end
    end
    check("mask_vary", 32'(obs_vary), 32'(exp_vary));

    // Consumer stalls for 10 cycles in DONE.
    run_op(1'($urandom), 1'($urandom), 10, 1'b0, mo, me);

    // Zero seed falls back to the default; reload during HOLD keeps masks.
    bus.seed_load = 1'b1;
    bus.seed = 16'h0000;
    @(negedge clk);
    bus.seed_load = 1'b0;
    check("zero_seed_lfsr", 32'(dut.u_lfsr.state), 32'(ref_lfsr));
    check("zero_seed_default", 32'(dut.u_lfsr.state), 32'(16'hACE1));
    run_op(1'b0, 1'b1, 1, 1'b1, mo, me);

    // Random traffic.
    for (int n = 0; n < 14; n++) begin
      ta = 1'($urandom);
      tb_b = 1'($urandom);
      run_op(ta, tb_b, int'($urandom_range(0, 3)), 1'($urandom), mo, me);
    end

    // Reset during HOLD discards the operation.
    bus.op_valid = 1'b1;
    bus.op_a = 1'b1;
    bus.op_b = 1'b0;
    @(negedge clk);
    bus.op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("hold_precharge", 32'(bus.gate_precharge), 32'(0));
    rst_n = 1'b0;
    @(negedge clk);
    exp_count = 16'h0000;
    check_quiet("mid_reset");
    check("mid_reset_count", 32'(bus.op_count), 32'(exp_count));
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("post_reset_valid", 32'(bus.res_valid), 32'(0));
      check("post_reset_ready", 32'(bus.op_ready), 32'(1));
    end
    check("post_reset_count", 32'(bus.op_count), 32'(exp_count));
    run_op(1'b1, 1'b1, 0, 1'b0, mo, me);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
